// File: rtl/sa_ctrl_if.sv
// Control/status bundle between a tile sequencer (sa_ctrl) and its requester.
// abort_i exists only when SA_CTRL_ABORT_EN is defined.
interface sa_ctrl_if #(
    parameter int PE_SIZE   = 4,
    parameter int CNT_WIDTH = 8
);
    // start_i is a single-cycle request with num_col_i valid alongside it; there is
    // no ready: a request is taken only when busy_o is low and num_col_i != 0,
    // otherwise it is dropped and the requester must re-issue it later.
    logic                 start_i;
    logic [CNT_WIDTH-1:0] num_col_i;
`ifdef SA_CTRL_ABORT_EN
    logic                 abort_i;
`endif
    logic                 ifmap_preload_o;
    logic                 weight_rd_en_o;
    logic [PE_SIZE-1:0]   weight_en_col_o;
    logic [PE_SIZE-1:0]   psum_en_row_o;
    logic                 out_valid_o;
    logic                 busy_o;
    logic                 done_o;
    logic [2:0]           dbg_state_o;

    modport master (
`ifdef SA_CTRL_ABORT_EN
        output abort_i,
`endif
        output start_i,
        output num_col_i,
        input  ifmap_preload_o,
        input  weight_rd_en_o,
        input  weight_en_col_o,
        input  psum_en_row_o,
        input  out_valid_o,
        input  busy_o,
        input  done_o,
        input  dbg_state_o
    );

    modport slave (
`ifdef SA_CTRL_ABORT_EN
        input  abort_i,
`endif
        input  start_i,
        input  num_col_i,
        output ifmap_preload_o,
        output weight_rd_en_o,
        output weight_en_col_o,
        output psum_en_row_o,
        output out_valid_o,
        output busy_o,
        output done_o,
        output dbg_state_o
    );
endinterface

// File: rtl/sa_ctrl.sv
// Systolic-array tile sequencer: preload, stream K weight vectors, drain, done.
// Optional abort input enabled by defining SA_CTRL_ABORT_EN.
module sa_ctrl #(
    parameter int PE_SIZE   = 4,
    parameter int CNT_WIDTH = 8
) (
    input logic        clk,
    input logic        rst,
    sa_ctrl_if.slave   bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRELOAD = 3'd1;
    localparam logic [2:0] S_STREAM  = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [CNT_WIDTH-1:0] PRE_LAST = CNT_WIDTH'(PE_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0] DRN_LAST = CNT_WIDTH'(2 * PE_SIZE - 2);

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_k;
    logic                 w_start_ok;
    logic                 w_abort;
    logic                 w_next_stream;

    logic                 r_preload;
    logic                 r_rd_en;
    logic [PE_SIZE-1:0]   r_col_sr;
    logic [PE_SIZE-1:0]   r_ov_sr;
    logic                 r_busy;
    logic                 r_done;

    assign w_start_ok = (r_state == S_IDLE) && bus.start_i && (bus.num_col_i != '0);

`ifdef SA_CTRL_ABORT_EN
    assign w_abort = bus.abort_i && (r_state != S_IDLE);
`else
    assign w_abort = 1'b0;
`endif

    // Phase counters always count from 0 up to (length-1), so K = 2^CNT_WIDTH-1
    // ends at 2^CNT_WIDTH-2 and never wraps.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next_state = S_PRELOAD;
            end
            S_PRELOAD: begin
                if (r_cnt == PRE_LAST) w_next_state = S_STREAM;
            end
            S_STREAM: begin
                if (r_cnt == (r_k - CNT_WIDTH'(1))) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_cnt == DRN_LAST) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
        if (w_abort) w_next_state = S_IDLE;
    end

    assign w_next_stream = (w_next_state == S_STREAM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_start_ok) begin
                r_k <= bus.num_col_i;
            end else if (w_abort) begin
                r_k <= '0;
            end
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == S_PRELOAD) || (r_state == S_STREAM) ||
                         (r_state == S_DRAIN)) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // Outputs are registered from the next state so each one lines up with
    // the cycle its state is actually occupied.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_preload <= 1'b0;
            r_rd_en   <= 1'b0;
            r_col_sr  <= '0;
            r_ov_sr   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (w_abort) begin
            r_preload <= 1'b0;
            r_rd_en   <= 1'b0;
            r_col_sr  <= '0;
            r_ov_sr   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_preload <= w_start_ok;
            r_rd_en   <= w_next_stream;
            r_col_sr  <= {r_col_sr[PE_SIZE-2:0], w_next_stream};
            r_ov_sr   <= {r_ov_sr[PE_SIZE-2:0], r_col_sr[PE_SIZE-1]};
            r_busy    <= (w_next_state != S_IDLE);
            r_done    <= (w_next_state == S_DONE);
        end
    end

    assign bus.ifmap_preload_o = r_preload;
    assign bus.weight_rd_en_o  = r_rd_en;
    assign bus.weight_en_col_o = r_col_sr;
    assign bus.psum_en_row_o   = r_col_sr;
    assign bus.out_valid_o     = r_ov_sr[PE_SIZE-1];
    assign bus.busy_o          = r_busy;
    assign bus.done_o          = r_done;
    assign bus.dbg_state_o     = r_state;
endmodule

// File: doc/sa_ctrl.md
SA_CTRL -- requirements
Module: sa_ctrl

Interface
REQ-001 Parameter PE_SIZE, default 4: systolic array dimension (rows = columns).
REQ-002 Parameter CNT_WIDTH, default 8: width of the stream-length field and internal counters.
REQ-003 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start_i  input  1  single-cycle request to run one tile.
REQ-007 num_col_i  input  CNT_WIDTH  weight vectors (K) to stream; sampled with start_i.
REQ-008 ifmap_preload_o  output  1  one-cycle preload pulse to the array.
REQ-009 weight_rd_en_o  output  1  weight-buffer read strobe, one vector per cycle.
REQ-010 weight_en_col_o  output  PE_SIZE  skewed per-column weight enables.
REQ-011 psum_en_row_o  output  PE_SIZE  skewed per-row psum enables.
REQ-012 out_valid_o  output  1  result row available at the array's psum output.
REQ-013 busy_o  output  1  tile in progress.
REQ-014 done_o  output  1  one-cycle tile-complete pulse.

Function
REQ-015 The FSM SHALL have states IDLE, PRELOAD, STREAM, DRAIN and DONE; all outputs are registered.
REQ-016 In IDLE, a start_i with num_col_i != 0 SHALL latch K and enter PRELOAD next cycle; start_i with num_col_i == 0 is ignored.
REQ-017 start_i outside IDLE SHALL be ignored, with no queuing.
REQ-018 ifmap_preload_o SHALL be high only in the first PRELOAD cycle; PRELOAD SHALL last exactly PE_SIZE cycles.
REQ-019 STREAM SHALL last exactly K cycles, with weight_rd_en_o and weight_en_col_o[0] high on every STREAM cycle and low otherwise.
REQ-020 weight_en_col_o[i] SHALL equal weight_en_col_o[0] delayed by i cycles, via a shift register; psum_en_row_o SHALL equal weight_en_col_o bit-for-bit.
REQ-021 out_valid_o SHALL equal weight_en_col_o[PE_SIZE-1] delayed by PE_SIZE cycles.
REQ-022 DRAIN SHALL last exactly 2*PE_SIZE-1 cycles, so the last out_valid_o falls in the final DRAIN cycle.
REQ-023 DONE SHALL last one cycle, assert done_o, then return to IDLE.
REQ-024 busy_o SHALL be high in PRELOAD, STREAM, DRAIN and DONE, and low in IDLE.
REQ-025 With start at cycle 0: preload pulse at cycle 1, STREAM cycles P+1..P+K, out_valid_o cycles 3P..3P+K-1, done_o at cycle 3P+K.
REQ-026 K = 2^CNT_WIDTH-1 SHALL stream exactly that many cycles; counters SHALL NOT wrap.
REQ-027 A new start_i is accepted in the cycle after DONE, giving back-to-back tiles with one IDLE cycle between them.

Reset
REQ-028 rst SHALL asynchronously force IDLE, clear counters, shift registers and latched K, and drive every output to 0.
REQ-029 Reset asserted mid-tile SHALL abandon the tile with no done_o; the first start_i after deassertion starts a fresh tile.

Configuration
REQ-030 With macro SA_CTRL_ABORT_EN defined, input abort_i (1 bit) SHALL exist.
REQ-031 With SA_CTRL_ABORT_EN defined, abort_i high in any non-IDLE state SHALL, on the next edge, enter IDLE and zero all outputs and skew registers, with no done_o.
REQ-032 With SA_CTRL_ABORT_EN defined, abort_i in IDLE is ignored, and abort_i has priority over start_i in the same cycle.
REQ-033 Without SA_CTRL_ABORT_EN, the abort_i port SHALL be absent and behaviour SHALL be as in REQ-015 to REQ-027.

Verification
REQ-034 P=4, start_i at cycle 0 with K=3 -> preload pulse at 1; weight_rd_en_o 5-7; weight_en_col_o[3] 8-10; out_valid_o 12-14; done_o 15; busy_o 1-15.
REQ-035 start_i with num_col_i=0 -> no output changes; busy_o stays 0.
REQ-036 start_i pulsed during STREAM -> ignored, timing identical to REQ-034; a second start at cycle 16 -> preload pulse at 17.
REQ-037 rst pulsed at cycle 6 of the REQ-034 run -> all outputs 0 immediately; done_o never asserts.
REQ-038 SA_CTRL_ABORT_EN defined, abort_i at cycle 9 -> all outputs 0 from cycle 10; no done_o; start at 11 -> preload pulse at 12.
REQ-039 K=255 with CNT_WIDTH=8 -> exactly 255 weight_rd_en_o cycles and 255 out_valid_o cycles; done_o at 3*4+255.
